hs32_fetch: RTL and testbench
=============================

HS32_FETCH -- requirements
Module: hs32_fetch

Interface
REQ-001 RESET_PC, 32'h0, fetch address loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 newpc  input  32  branch target supplied by the execute stage.
REQ-005 flush  input  1  one-cycle pulse from the execute stage: discard buffered or in-flight instructions and refetch from newpc.
REQ-006 addr  output  32  memory arbiter fetch address.
REQ-007 dtrm  input  32  memory arbiter read data.
REQ-008 reqm  output  1  memory request (read only).
REQ-009 rdym  input  1  memory data valid.
REQ-010 instd  output  32  instruction word at the buffer head, to decode.
REQ-011 pcd  output  32  fetch address of instd.
REQ-012 reqd  output  1  buffer head valid.
REQ-013 rdyd  input  1  decode accepts the head.

Function
REQ-014 Internal state: fetch PC, instruction buffer of DEPTH entries holding {instr, pc}, count, and FSM with states IDLE, FETCH and DROP.
REQ-015 IDLE, no flush, count < DEPTH: reqm<=1, addr<=pc, go FETCH; count == DEPTH: stay IDLE, reqm stays 0.
REQ-016 FETCH, no flush, rdym=1: push {dtrm, pc}, pc<=pc+4 (wraps modulo 2^32), reqm<=0, go IDLE; rdym=0: hold reqm=1 and addr unchanged.
REQ-017 Memory handshake completes only in a cycle with reqm && rdym; rdym while reqm=0 is ignored.
REQ-018 Throughput with rdym tied high: one instruction every 2 cycles; reqm high in FETCH, low in IDLE.
REQ-019 reqd = (count != 0); instd/pcd = head entry (combinational from buffer); pop when reqd && rdyd.
REQ-020 Simultaneous push and pop in one cycle: count unchanged, FIFO order preserved.
REQ-021 Full: push never occurs with count == DEPTH, because a request is issued only when a free slot exists (REQ-015).
REQ-022 flush has priority over push, pop and request issue: count<=0, pc<=newpc; reqd reads 0 from the next cycle.
REQ-023 flush in IDLE: no request that cycle, stay IDLE.
REQ-024 flush in FETCH with rdym=1: discard dtrm, reqm<=0, go IDLE.
REQ-025 flush in FETCH with rdym=0: go DROP with reqm held 1.
REQ-026 DROP: on rdym, discard dtrm, reqm<=0, go IDLE; flush in DROP updates pc to the newest newpc and stays DROP.
REQ-027 Latency from flush in IDLE with rdym tied high: reqm high at flush+2 cycles with addr=newpc; reqd high at flush+3.
REQ-028 Instructions fetched before a flush never appear on instd after the flush.

Reset
REQ-029 On reset: pc=RESET_PC, count=0, state=IDLE, reqm=0, addr=0, reqd=0; buffer data contents don't-care.
REQ-030 Reset asserted mid-transaction aborts it immediately; reqm=0 next cycle, and the in-flight data is never pushed.

Configuration
REQ-031 Macro HS32_PREFETCH_EN defined: DEPTH=4, circular buffer with 2-bit read/write pointers wrapping 3->0.
REQ-032 HS32_PREFETCH_EN undefined: DEPTH=1, single holding register; the next request is issued only after the held word is popped (count returns to 0).
REQ-033 All other behaviour is identical in both builds.

Verification
REQ-034 Reset release, RESET_PC=0, rdym=1, rdyd=1, mem[i]=i*4+0x100 -> reqm pulses on alternate cycles; instd/pcd sequence (0x100,0), (0x104,4), (0x108,8) in order.
REQ-035 rdyd=0, rdym=1 -> with HS32_PREFETCH_EN, exactly 4 fetches then reqm stays 0; without the macro, exactly 1 fetch; then rdyd=1 drains in order with no loss or duplication.
REQ-036 flush with newpc=0x2000 while in FETCH and rdym=0 for 3 cycles -> reqm stays high with old addr; data on rdym is dropped; next request addr=0x2000; first instd after flush has pcd=0x2000.
REQ-037 flush in the same cycle as push and pop, count=2 -> count=0, reqd=0 next cycle, and neither word appears.
REQ-038 RESET_PC=32'hFFFF_FFFC, rdym=1 -> pcd sequence 0xFFFFFFFC, 0x00000000.
REQ-039 reset asserted while reqm=1, rdym=0 -> reqm=0 and reqd=0 next cycle; first post-reset request addr=RESET_PC.

Source files
------------

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: memory request FSM feeding an instruction buffer for decode.
// Define HS32_PREFETCH_EN for a 4-entry prefetch buffer; otherwise a single holding register.
module hs32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newpc,
  input  logic        flush,
  output logic [31:0] addr,
  input  logic [31:0] dtrm,
  output logic        reqm,
  input  logic        rdym,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqd,
  input  logic        rdyd
);

`ifdef HS32_PREFETCH_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [2:0]  r_count;
  logic        w_push;
  logic        w_pop;

  // Flush outranks both buffer operations; a drop cycle never pushes.
  assign w_push = (r_state == S_FETCH) && rdym && !flush;
  assign w_pop  = (r_count != '0) && rdyd && !flush;
  assign reqd   = (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      reqm    <= 1'b0;
      addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_pc <= newpc;
          end else if (r_count < DEPTH) begin
            reqm    <= 1'b1;
            addr    <= r_pc;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (flush) begin
            r_pc <= newpc;
            if (rdym) begin
              reqm    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DROP;
            end
          end else if (rdym) begin
            r_pc    <= r_pc + 32'd4;
            reqm    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          // The stale request must still complete on the bus before refetching.
          if (flush) r_pc <= newpc;
          if (rdym) begin
            reqm    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          reqm    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 3'd1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 3'd1;
    end
  end

`ifdef HS32_PREFETCH_EN
  logic [31:0] r_instr [4];
  logic [31:0] r_bpc   [4];
  logic [1:0]  r_rptr;
  logic [1:0]  r_wptr;

  assign instd = r_instr[r_rptr];
  assign pcd   = r_bpc[r_rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_instr[r_wptr] <= dtrm;
      r_bpc[r_wptr]   <= r_pc;
    end
  end
`else
  logic [31:0] r_instr;
  logic [31:0] r_bpc;

  assign instd = r_instr;
  assign pcd   = r_bpc;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_instr <= dtrm;
      r_bpc   <= r_pc;
    end
  end
`endif

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: directed scenarios plus random traffic against a transaction-level scoreboard.
module tb_hs32_fetch;
`ifdef HS32_PREFETCH_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int          PERIOD  = (DEPTH > 1) ? 2 : 3;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        rdym = 1'b0;
  logic        rdyd = 1'b0;
  logic [31:0] newpc = '0;
  logic [31:0] addr, dtrm, instd, pcd;
  logic        reqm, reqd;
  logic [31:0] addr_w, dtrm_w, instd_w, pcd_w;
  logic        reqm_w, reqd_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  assign dtrm   = mem(addr);
  assign dtrm_w = mem(addr_w);

  hs32_fetch #(.RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .newpc(newpc), .flush(flush), .addr(addr), .dtrm(dtrm),
    .reqm(reqm), .rdym(rdym), .instd(instd), .pcd(pcd), .reqd(reqd), .rdyd(rdyd)
  );

  hs32_fetch #(.RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk(clk), .reset(reset), .newpc(newpc), .flush(flush), .addr(addr_w), .dtrm(dtrm_w),
    .reqm(reqm_w), .rdym(rdym), .instd(instd_w), .pcd(pcd_w), .reqd(reqd_w), .rdyd(rdyd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected instruction stream is a PC sequence restarted by flush/reset.
  logic [31:0] m_fetch_pc = '0;
  logic [31:0] m_exp_pc   = '0;
  logic [31:0] m_drop_addr = '0;
  int          m_occ = 0;
  int          m_pushes = 0;
  bit          m_drop = 1'b0;
  bit          p_reset = 1'b1, p_reqm = 1'b0, p_rdym = 1'b0, p_flush = 1'b0;
  int          p_occ = 0;
  int          w_cnt = 0;

  always @(negedge clk) begin
    bit pop;
    if (reset) begin
      m_fetch_pc = '0;
      m_exp_pc   = '0;
      m_occ      = 0;
      m_drop     = 1'b0;
      p_reset    = 1'b1;
      p_reqm     = 1'b0;
      p_flush    = 1'b0;
    end else begin
      if (p_reset) begin
        check("rst_reqm", reqm, 0);
        check("rst_reqd", reqd, 0);
        check("rst_addr", addr, 0);
      end else if (p_reqm && p_rdym) begin
        check("reqm_after_hs", reqm, 0);
      end else if (p_reqm) begin
        check("reqm_hold", reqm, 1);
      end else begin
        check("reqm_issue", reqm, !p_flush && (p_occ < DEPTH));
      end
      check("reqd", reqd, m_occ != 0);
      if (reqd) begin
        check("head_pc", pcd, m_exp_pc);
        check("head_instr", instd, mem(m_exp_pc));
      end
      if (reqm) check("fetch_addr", addr, m_drop ? m_drop_addr : m_fetch_pc);

      if (w_cnt < 2 && reqd_w && rdyd) begin
        check("wrap_pcd", pcd_w, (w_cnt == 0) ? WRAP_PC : 32'h0);
        check("wrap_instr", instd_w, mem((w_cnt == 0) ? WRAP_PC : 32'h0));
        w_cnt++;
      end

      p_occ   = m_occ;
      p_reqm  = reqm;
      p_rdym  = rdym;
      p_flush = flush;
      p_reset = 1'b0;
      pop     = (m_occ != 0) && rdyd;
      if (flush) begin
        if (reqm && !rdym) begin
          m_drop      = 1'b1;
          m_drop_addr = addr;
        end else begin
          m_drop = 1'b0;
        end
        m_occ      = 0;
        m_fetch_pc = newpc;
        m_exp_pc   = newpc;
      end else begin
        if (reqm && rdym) begin
          if (m_drop) m_drop = 1'b0;
          else begin
            m_occ++;
            m_pushes++;
            m_fetch_pc += 32'd4;
          end
        end
        if (pop) begin
          m_occ--;
          m_exp_pc += 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reqm(input string tag);
    int n = 0;
    while (reqm !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (reqm !== 1'b1) check(tag, reqm, 1);
  endtask

  task automatic wait_reqd(input string tag);
    int n = 0;
    while (reqd !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (reqd !== 1'b1) check(tag, reqd, 1);
  endtask

  initial begin
    logic [31:0] old_addr;
    int occ0, push0, target, n;

    rdym = 1'b1;
    rdyd = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Streaming from reset: request cadence and in-order delivery.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("cadence_reqm", reqm, (i % PERIOD) == 1);
    end
    tick();

    // Decode stalled: buffer fills to DEPTH, then drains in order.
    rdyd  = 1'b0;
    occ0  = m_occ;
    push0 = m_pushes;
    repeat (20) tick();
    check("fill_pushes", m_pushes - push0, DEPTH - occ0);
    check("full_reqm", reqm, 0);
    check("full_reqd", reqd, 1);
    rdyd = 1'b1;
    repeat (16) tick();

    // Flush while a fetch is stalled: old request stays up, its data is dropped.
    rdym = 1'b0;
    wait_reqm("pre_flush_req");
    old_addr = addr;
    newpc = 32'h2000;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_reqm", reqm, 1);
      check("drop_addr", addr, old_addr);
      tick();
    end
    rdym = 1'b1;
    tick();
    check("drop_done_reqm", reqm, 0);
    wait_reqm("post_flush_req");
    check("post_flush_addr", addr, 32'h2000);
    wait_reqd("post_flush_reqd");
    check("post_flush_pcd", pcd, 32'h2000);

    // Flush coinciding with push and pop on a partly filled buffer.
    rdym   = 1'b0;
    rdyd   = 1'b0;
    target = (DEPTH > 1) ? 2 : 1;
    n = 0;
    while (m_occ < target && n < 40) begin
      rdym = reqm;
      tick();
      rdym = 1'b0;
      n++;
    end
    if (m_occ < target) check("fill_timeout", 0, 1);
    if (DEPTH > 1) wait_reqm("pre_collide_req");
    newpc = 32'h3000;
    flush = 1'b1;
    rdym  = 1'b1;
    rdyd  = 1'b1;
    tick();
    flush = 1'b0;
    rdym  = 1'b0;
    check("collide_reqd", reqd, 0);
    check("collide_reqm", reqm, 0);
    rdym = 1'b1;
    wait_reqd("post_collide_reqd");
    check("post_collide_pcd", pcd, 32'h3000);
    check("post_collide_instr", instd, mem(32'h3000));

    // Reset during an outstanding request.
    rdym = 1'b0;
    wait_reqm("pre_rst_req");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_reqm", reqm, 0);
    check("midrst_reqd", reqd, 0);
    rdym = 1'b1;
    wait_reqm("post_rst_req");
    check("post_rst_addr", addr, 32'h0);

    // Random traffic against the scoreboard.
    repeat (1500) begin
      rdym  = ($urandom_range(0, 9) < 7);
      rdyd  = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 199) == 0);
      newpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
    repeat (2) tick();

    check("wrap_pop_count", w_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
